addsub_display: RTL
===================

# addsub_display

Downstream display stage for the 2-bit adder/subtractor on the board's 4-digit seven-segment display. It consumes the operands, mode bit and result (`s`, `cout`) and interprets them as an unsigned sum or a signed difference. It time-multiplexes four digits, showing operand a, operand b, a sign, and the result magnitude. It latches a coherent snapshot of its inputs once per scan frame so that the digits never tear.

## Interface
- `REFRESH_DIV`, 100_000, clock cycles per digit slot (≥1); 1 kHz per digit at 100 MHz.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `a`  input  2  operand a as applied to the adder/subtractor.
- `b`  input  2  operand b, un-inverted.
- `m`  input  1  mode: 0 = add, 1 = subtract.
- `s`  input  2  result bits from the adder/subtractor.
- `cout`  input  1  add mode: carry-out. Subtract mode: borrow (1 ⇒ a<b).
- `seg`  output  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  output  1  decimal point, active-low; held 1.
- `an`  output  4  digit anodes, active-low, one-hot-low; an[3] is the leftmost digit.

## Operation
- Refresh counter `cnt` counts 0..REFRESH_DIV-1 and then wraps. `tick` is asserted when `cnt == REFRESH_DIV-1`.
- On `tick`, the digit index `idx` (2 bits) advances 0→1→2→3→0.
- Snapshot register {a,b,m,s,cout} loads on the tick where `idx == 3`, i.e. at frame start. Inputs are ignored at all other times.
- Value decode, computed from the snapshot:
  - m=0: value = {cout,s}, range 0..6, sign blank.
  - m=1, cout=0: value = s, sign blank.
  - m=1, cout=1: value = (~s + 1) mod 4, range 1..3, sign '-'.
- Digit contents:
  - idx 0 → value, an=1110.
  - idx 1 → sign, an=1101.
  - idx 2 → b, an=1011.
  - idx 3 → a, an=0111.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010.
  - '-'=0111111, blank=1111111.
- Inputs are not cross-checked. The block displays whatever result it is given. Values 7..15 cannot occur and decode to blank.

## Timing
- Reset values: cnt=0, idx=0, snapshot=all zeros, an=1111, seg=1111111, dp=1.
- `an`/`seg` are registered and reflect `idx` and the snapshot with 1-cycle latency.
  - First cycle after reset deasserts: an=1111.
  - Second cycle onward: an=1110, seg='0'.
- Each digit is driven for exactly REFRESH_DIV cycles. A frame lasts 4·REFRESH_DIV cycles.
- An input change becomes visible at most 4·REFRESH_DIV+1 cycles later. It appears at the first frame boundary after the change.
- With REFRESH_DIV=1, `tick` fires every cycle and `idx` increments every cycle.
- Reset asserted mid-frame takes effect on the next edge: all state returns to reset values and the partial frame is discarded.
- Snapshot load and `idx` wrap happen on the same edge. The digit-0 slot that follows shows the new snapshot.

## Structure
- Package `addsub_disp_pkg` holds:
  - segment constants: SEG_0..SEG_6, SEG_MINUS, SEG_BLANK;
  - `digit_idx_t` (2-bit);
  - anode pattern constants AN_OFF, AN_D0..AN_D3.
- Sub-module `seg7_decode`: combinational map from a 3-bit value plus a blank/minus select to `seg`. It is instantiated once, on the muxed digit.
- The top module contains the counter, the index, the snapshot register, the sign/magnitude decode and the output registers.

## Test plan
All scenarios run with REFRESH_DIV=4.
- Reset for 3 cycles, then release → one cycle of an=1111 and seg=1111111, then an=1110 and seg=1000000. The anode sequence is 1110,1101,1011,0111, with each value held 4 cycles.
- Add, a=3, b=3, m=0, s=2, cout=1 applied before the frame boundary → next frame shows value '6' (0000010), sign blank, b '3' (0110000), a '3'.
- Subtract, a=1, b=3, m=1, s=2, cout=1 → next frame shows value '2' (0100100) and sign '-' (0111111).
- Subtract, a=3, b=1, m=1, s=2, cout=0 → next frame shows value '2' and sign blank.
- Change inputs mid-frame (idx=1) → digits 1–3 of the current frame still show the old snapshot; the new values appear from the next digit-0 slot.
- Assert reset for 1 cycle during idx=2 → next cycle an=1111 and the snapshot is cleared. The scan then restarts at digit 0 showing '0'.

Source files
------------

// File: rtl/addsub_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_disp_pkg
//  Description : Shared types and constants for the adder/subtractor
//                seven-segment display stage (segment codes, anode
//                patterns, digit index and snapshot types).
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_disp_pkg;

   // Digit slot index; slot 0 is the rightmost digit.
   typedef logic [1:0] digit_idx_t;

   // What the segment decoder should draw for the current digit.
   typedef enum logic [1:0] {
      SEL_NUM   = 2'd0,
      SEL_MINUS = 2'd1,
      SEL_BLANK = 2'd2
   } seg_sel_t;

   // Coherent copy of the adder/subtractor inputs, taken once per frame.
   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       m;
      logic [1:0] s;
      logic       cout;
   } snapshot_t;

   // Segment codes {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Anode patterns, active-low; AN_D3 is the leftmost digit.
   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [3:0] AN_D0  = 4'b1110;
   localparam logic [3:0] AN_D1  = 4'b1101;
   localparam logic [3:0] AN_D2  = 4'b1011;
   localparam logic [3:0] AN_D3  = 4'b0111;

   // Role of each digit slot.
   localparam digit_idx_t IDX_VALUE = 2'd0;
   localparam digit_idx_t IDX_SIGN  = 2'd1;
   localparam digit_idx_t IDX_B     = 2'd2;
   localparam digit_idx_t IDX_A     = 2'd3;

   // Anode pattern that enables the given digit slot.
   function automatic logic [3:0] an_pattern(input digit_idx_t idx);
      logic [3:0] pat;
      case (idx)
         IDX_VALUE: pat = AN_D0;
         IDX_SIGN:  pat = AN_D1;
         IDX_B:     pat = AN_D2;
         default:   pat = AN_D3;
      endcase
      return pat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational seven-segment decoder. Draws digits 0..6,
//                a minus sign or a blank; unsupported values draw blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
   import addsub_disp_pkg::*;
(
   input  logic [2:0] value,
   input  seg_sel_t   sel,
   output logic [6:0] seg
);

   // Map the selected symbol to its active-low segment pattern.
   always_comb begin
      seg = SEG_BLANK;
      case (sel)
         SEL_MINUS: seg = SEG_MINUS;
         SEL_NUM: begin
            case (value)
               3'd0:    seg = SEG_0;
               3'd1:    seg = SEG_1;
               3'd2:    seg = SEG_2;
               3'd3:    seg = SEG_3;
               3'd4:    seg = SEG_4;
               3'd5:    seg = SEG_5;
               3'd6:    seg = SEG_6;
               default: seg = SEG_BLANK;
            endcase
         end
         default: seg = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/addsub_display.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_display
//  Description : Four-digit multiplexed display of a 2-bit adder/subtractor.
//                Shows [a][b][sign][value] from a snapshot taken once per
//                scan frame, so a frame never mixes old and new inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_display
   import addsub_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100_000
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       m,
   input  logic [1:0] s,
   input  logic       cout,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   // A single-cycle slot still needs a 1-bit counter to stay well formed.
   localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tick;
   digit_idx_t       r_idx;
   snapshot_t        r_snap;
   snapshot_t        w_snap_in;
   logic [1:0]       w_neg_mag;
   logic [2:0]       w_mag;
   logic             w_neg;
   logic [2:0]       w_digit;
   seg_sel_t         w_sel;
   logic [6:0]       w_seg;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;

   assign w_tick    = (r_cnt == c_cnt_max);
   assign w_snap_in = '{a: a, b: b, m: m, s: s, cout: cout};

   // Refresh counter: one full count per digit slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Digit index advances once per slot and wraps naturally after slot 3.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx <= IDX_VALUE;
      end else if (w_tick) begin
         r_idx <= r_idx + 2'd1;
      end
   end

   // Snapshot is taken as the last slot ends, so the new frame starts coherent.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap <= '0;
      end else if (w_tick && (r_idx == IDX_A)) begin
         r_snap <= w_snap_in;
      end
   end

   // Two's-complement negation of the difference when a borrow occurred.
   assign w_neg_mag = 2'(~r_snap.s + 2'd1);

   // Sign/magnitude decode: add is unsigned {cout,s}; subtract with borrow is negative.
   always_comb begin
      w_neg = 1'b0;
      w_mag = {r_snap.cout, r_snap.s};
      if (r_snap.m) begin
         if (r_snap.cout) begin
            w_neg = 1'b1;
            w_mag = {1'b0, w_neg_mag};
         end else begin
            w_mag = {1'b0, r_snap.s};
         end
      end
   end

   // Pick what the active digit slot should show.
   always_comb begin
      w_digit = 3'd0;
      w_sel   = SEL_NUM;
      case (r_idx)
         IDX_VALUE: w_digit = w_mag;
         IDX_SIGN:  w_sel   = w_neg ? SEL_MINUS : SEL_BLANK;
         IDX_B:     w_digit = {1'b0, r_snap.b};
         default:   w_digit = {1'b0, r_snap.a};
      endcase
   end

   seg7_decode u_seg7_decode (
      .value (w_digit),
      .sel   (w_sel),
      .seg   (w_seg)
   );

   // Output registers keep anodes and segments switching on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_BLANK;
      end else begin
         r_an  <= an_pattern(r_idx);
         r_seg <= w_seg;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = 1'b1;

endmodule
`default_nettype wire
